// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage and the data memory.
// It carries a req/ack handshake with variable latency.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RISC-V pipeline: it runs loads and stores on the req/ack data bus.
// It stalls the pipeline while the bus is busy and owns the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                EX_MEM_valid,
    input  logic                EX_MEM_mem_read,
    input  logic                EX_MEM_mem_write,
    input  logic [2:0]          EX_MEM_funct3,
    input  logic                EX_MEM_mem_to_reg,
    input  logic                EX_MEM_reg_write,
    input  logic [4:0]          EX_MEM_rd,
    input  logic [31:0]         EX_MEM_alu_out,
    input  logic [31:0]         EX_MEM_rs2_data,
    mem_access_stage_if.master  dmem,
    output logic                mem_stall,
    output logic                MEM_WB_valid,
    output logic                MEM_WB_reg_write,
    output logic                MEM_WB_mem_to_reg,
    output logic [4:0]          MEM_WB_rd,
    output logic [31:0]         MEM_WB_alu_out,
    output logic [31:0]         MEM_WB_mem_data,
    output logic                MEM_WB_misalign,
    output logic                MEM_WB_bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;

    logic        is_byte_s, is_half_s, aligned_s, mem_op_s;
    logic        acc_s, misalign_s, timeout_s, store_s, load_done_s;
    logic [3:0]  be_raw_s;
    logic [31:0] wdata_s, load_data_s;

    // Pick the addressed lane, then sign/zero extend it; unused funct3 codes behave as LW.
    function automatic logic [31:0] extend_load(input logic [2:0]  funct3,
                                                input logic [1:0]  offset,
                                                input logic [31:0] word);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  result = {{24{lane_b[7]}}, lane_b};
            3'b100:  result = {24'h00_0000, lane_b};
            3'b001:  result = {{16{lane_h[15]}}, lane_h};
            3'b101:  result = {16'h0000, lane_h};
            default: result = word;
        endcase
        return result;
    endfunction

    assign is_byte_s   = (EX_MEM_funct3 == 3'b000) | (EX_MEM_funct3 == 3'b100);
    assign is_half_s   = (EX_MEM_funct3 == 3'b001) | (EX_MEM_funct3 == 3'b101);
    assign aligned_s   = is_byte_s
                       | (is_half_s & ~EX_MEM_alu_out[0])
                       | (~is_byte_s & ~is_half_s & (EX_MEM_alu_out[1:0] == 2'b00));
    assign mem_op_s    = EX_MEM_valid & (EX_MEM_mem_read | EX_MEM_mem_write);
    assign acc_s       = mem_op_s & aligned_s;
    assign misalign_s  = mem_op_s & ~aligned_s;
    assign store_s     = acc_s & EX_MEM_mem_write;
    assign timeout_s   = acc_s & (state_r == BUSY) & ~dmem.dmem_ack & (cnt_r == CNT_LIMIT);
    assign load_done_s = acc_s & EX_MEM_mem_read & ~EX_MEM_mem_write & dmem.dmem_ack;
    assign load_data_s = load_done_s ? extend_load(EX_MEM_funct3, EX_MEM_alu_out[1:0], dmem.dmem_rdata)
                                     : 32'h0000_0000;

    // Bus outputs; the request is withdrawn during the cycle the access gives up.
    assign dmem.dmem_req   = acc_s & ~timeout_s;
    assign dmem.dmem_we    = store_s;
    assign dmem.dmem_addr  = {EX_MEM_alu_out[31:2], 2'b00};
    assign dmem.dmem_be    = store_s ? be_raw_s : 4'b0000;
    assign dmem.dmem_wdata = wdata_s;

    // Byte-enable pattern and lane-replicated store data by access size.
    always_comb begin
        be_raw_s = 4'b1111;
        wdata_s  = EX_MEM_rs2_data;
        if (is_byte_s) begin
            be_raw_s = 4'b0001 << EX_MEM_alu_out[1:0];
            wdata_s  = {4{EX_MEM_rs2_data[7:0]}};
        end else if (is_half_s) begin
            be_raw_s = 4'b0011 << EX_MEM_alu_out[1:0];
            wdata_s  = {2{EX_MEM_rs2_data[15:0]}};
        end else begin
            be_raw_s = 4'b1111;
            wdata_s  = EX_MEM_rs2_data;
        end
    end

    // Next-state, wait counter and stall decode for the bus FSM.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        mem_stall    = 1'b0;
        case (state_r)
            IDLE: begin
                if (acc_s & ~dmem.dmem_ack) begin
                    next_state_s = BUSY;
                    cnt_next_s   = CNT_ONE;
                    mem_stall    = 1'b1;
                end else begin
                    next_state_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end
            end
            BUSY: begin
                if (~acc_s | dmem.dmem_ack | (cnt_r == CNT_LIMIT)) begin
                    next_state_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    next_state_s = BUSY;
                    cnt_next_s   = cnt_r + CNT_ONE;
                    mem_stall    = 1'b1;
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM state and wait counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // MEM/WB pipeline register: a bubble while stalled, otherwise this stage's results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            MEM_WB_valid      <= 1'b0;
            MEM_WB_reg_write  <= 1'b0;
            MEM_WB_mem_to_reg <= 1'b0;
            MEM_WB_rd         <= 5'd0;
            MEM_WB_alu_out    <= 32'h0000_0000;
            MEM_WB_mem_data   <= 32'h0000_0000;
            MEM_WB_misalign   <= 1'b0;
            MEM_WB_bus_err    <= 1'b0;
        end else if (mem_stall) begin
            MEM_WB_valid      <= 1'b0;
            MEM_WB_reg_write  <= 1'b0;
            MEM_WB_misalign   <= 1'b0;
            MEM_WB_bus_err    <= 1'b0;
        end else begin
            MEM_WB_valid      <= EX_MEM_valid;
            MEM_WB_reg_write  <= EX_MEM_reg_write & ~misalign_s & ~timeout_s;
            MEM_WB_mem_to_reg <= EX_MEM_mem_to_reg;
            MEM_WB_rd         <= EX_MEM_rd;
            MEM_WB_alu_out    <= EX_MEM_alu_out;
            MEM_WB_mem_data   <= load_data_s;
            MEM_WB_misalign   <= misalign_s;
            MEM_WB_bus_err    <= timeout_s;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a small memory responder with chosen latencies,
// checked against a transaction-level model of each instruction's effect.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_read, ex_write, ex_m2r, ex_rw;
    logic [2:0]  ex_f3;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu, ex_rs2;
    logic        mem_stall;
    logic        wb_valid, wb_rw, wb_m2r, wb_misalign, wb_bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu, wb_mdata;

    int checks;
    int failures;

    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_mdata;
    logic        m_m2r;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .EX_MEM_valid      (ex_valid),
        .EX_MEM_mem_read   (ex_read),
        .EX_MEM_mem_write  (ex_write),
        .EX_MEM_funct3     (ex_f3),
        .EX_MEM_mem_to_reg (ex_m2r),
        .EX_MEM_reg_write  (ex_rw),
        .EX_MEM_rd         (ex_rd),
        .EX_MEM_alu_out    (ex_alu),
        .EX_MEM_rs2_data   (ex_rs2),
        .dmem              (bus),
        .mem_stall         (mem_stall),
        .MEM_WB_valid      (wb_valid),
        .MEM_WB_reg_write  (wb_rw),
        .MEM_WB_mem_to_reg (wb_m2r),
        .MEM_WB_rd         (wb_rd),
        .MEM_WB_alu_out    (wb_alu),
        .MEM_WB_mem_data   (wb_mdata),
        .MEM_WB_misalign   (wb_misalign),
        .MEM_WB_bus_err    (wb_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference load result: shift the addressed lane down, mask, then extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] x;
        x = w >> (32'(off) * 32'd8);
        if (f3 == 3'd0 || f3 == 3'd4) begin
            x = x & 32'h0000_00FF;
            if (f3 == 3'd0 && x[7]) x = x | 32'hFFFF_FF00;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            x = x & 32'h0000_FFFF;
            if (f3 == 3'd1 && x[15]) x = x | 32'hFFFF_0000;
        end else begin
            x = w;
        end
        return x;
    endfunction

    task automatic check_wb_zero(input string tag);
        check_eq({tag, "_valid"},    32'(wb_valid),    32'd0);
        check_eq({tag, "_rw"},       32'(wb_rw),       32'd0);
        check_eq({tag, "_m2r"},      32'(wb_m2r),      32'd0);
        check_eq({tag, "_rd"},       32'(wb_rd),       32'd0);
        check_eq({tag, "_alu"},      wb_alu,           32'd0);
        check_eq({tag, "_mdata"},    wb_mdata,         32'd0);
        check_eq({tag, "_misalign"}, 32'(wb_misalign), 32'd0);
        check_eq({tag, "_buserr"},   32'(wb_bus_err),  32'd0);
    endtask

    // Present one instruction (at posedge+1) and follow it until it leaves the stage.
    // lat = cycle index on which memory acks; lat > TO never acks in time.
    task automatic run_instr(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                             input logic m2r, input logic rw, input logic [4:0] rd,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdv, input int lat);
        logic [1:0]  off;
        logic        is_b, is_h, al, acc, berr, stall_e, done, mis, rw_e;
        logic [3:0]  be_e;
        logic [31:0] wd_e, md_e;
        ex_valid = v; ex_read = ld; ex_write = st; ex_f3 = f3; ex_m2r = m2r;
        ex_rw = rw; ex_rd = rd; ex_alu = addr; ex_rs2 = wd;
        off  = addr[1:0];
        is_b = (f3 == 3'd0) || (f3 == 3'd4);
        is_h = (f3 == 3'd1) || (f3 == 3'd5);
        al   = is_b || (is_h && !off[0]) || (!is_b && !is_h && off == 2'd0);
        acc  = v && (ld || st) && al;
        mis  = v && (ld || st) && !al;
        berr = acc && (lat > TO);
        be_e = 4'd0;
        if (acc && st) be_e = is_b ? (4'd1 << off) : (is_h ? (4'd3 << off) : 4'hF);
        wd_e = is_b ? 32'(wd[7:0]) * 32'h0101_0101 : (is_h ? 32'(wd[15:0]) * 32'h0001_0001 : wd);
        done = 1'b0;
        for (int k = 0; k <= TO && !done; k++) begin
            bus.dmem_ack   = acc ? (k == lat) : 1'($urandom_range(0, 1));
            bus.dmem_rdata = rdv;
            @(negedge clk);
            stall_e = acc && (k < lat) && (k < TO);
            check_eq("stall", 32'(mem_stall), 32'(stall_e));
            check_eq("req",   32'(bus.dmem_req), 32'(acc && !(k >= TO && lat > TO)));
            check_eq("we",    32'(bus.dmem_we), 32'(acc && st));
            check_eq("be",    32'(bus.dmem_be), 32'(be_e));
            if (acc) check_eq("addr", bus.dmem_addr, addr & 32'hFFFF_FFFC);
            if (acc && st) check_eq("wdata", bus.dmem_wdata, wd_e);
            @(posedge clk);
            #1;
            if (stall_e) begin
                check_eq("bub_valid",    32'(wb_valid), 32'd0);
                check_eq("bub_rw",       32'(wb_rw), 32'd0);
                check_eq("bub_misalign", 32'(wb_misalign), 32'd0);
                check_eq("bub_buserr",   32'(wb_bus_err), 32'd0);
                check_eq("hold_rd",      32'(wb_rd), 32'(m_rd));
                check_eq("hold_alu",     wb_alu, m_alu);
                check_eq("hold_m2r",     32'(wb_m2r), 32'(m_m2r));
                check_eq("hold_mdata",   wb_mdata, m_mdata);
            end else begin
                rw_e = rw && !mis && !berr;
                md_e = (acc && ld && !st && !berr) ? ref_load(f3, off, rdv) : 32'd0;
                check_eq("wb_valid",    32'(wb_valid), 32'(v));
                check_eq("wb_rw",       32'(wb_rw), 32'(rw_e));
                check_eq("wb_m2r",      32'(wb_m2r), 32'(m2r));
                check_eq("wb_rd",       32'(wb_rd), 32'(rd));
                check_eq("wb_alu",      wb_alu, addr);
                check_eq("wb_mdata",    wb_mdata, md_e);
                check_eq("wb_misalign", 32'(wb_misalign), 32'(mis));
                check_eq("wb_buserr",   32'(wb_bus_err), 32'(berr));
                m_rd = rd; m_alu = addr; m_m2r = m2r; m_mdata = md_e;
                done = 1'b1;
            end
        end
        if (!done) check_eq("instr_retire", 32'd0, 32'd1);
        bus.dmem_ack = 1'b0;
    endtask

    initial begin
        logic [2:0] ld_f3 [8];
        logic [2:0] f3;
        int         kind, lat;
        logic [31:0] a;

        checks = 0; failures = 0;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        m_rd = 5'd0; m_alu = 32'd0; m_m2r = 1'b0; m_mdata = 32'd0;
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_read = 1'b0; ex_write = 1'b0; ex_f3 = 3'd0; ex_m2r = 1'b0;
        ex_rw = 1'b0; ex_rd = 5'd0; ex_alu = 32'd0; ex_rs2 = 32'd0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_wb_zero("rst");
        check_eq("rst_stall", 32'(mem_stall), 32'd0);
        rst_n = 1'b1;

        // Directed cases: ALU op, LB zero-wait, SH with 3 wait cycles, misaligned LW, timeout.
        run_instr(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'd0, 32'd0, 0);
        run_instr(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 5'd7, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0);
        check_eq("lb_example", wb_mdata, 32'hFFFF_FF80);
        run_instr(1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 5'd0, 32'h0000_0202, 32'h0000_ABCD, 32'd0, 3);
        run_instr(1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 5'd9, 32'h0000_0101, 32'd0, 32'h1111_2222, 0);
        run_instr(1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 5'd10, 32'h0000_0400, 32'd0, 32'h5555_AAAA, 9);

        // LHU stuck in BUSY, then reset together with the upstream EX/MEM flush.
        ex_valid = 1'b1; ex_read = 1'b1; ex_write = 1'b0; ex_f3 = 3'd5; ex_m2r = 1'b1;
        ex_rw = 1'b1; ex_rd = 5'd12; ex_alu = 32'h0000_0302; ex_rs2 = 32'd0;
        bus.dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("busy_stall", 32'(mem_stall), 32'd1);
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_read = 1'b0; ex_f3 = 3'd0; ex_m2r = 1'b0;
        ex_rw = 1'b0; ex_rd = 5'd0; ex_alu = 32'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_wb_zero("midrst");
        check_eq("midrst_stall", 32'(mem_stall), 32'd0);
        check_eq("midrst_req", 32'(bus.dmem_req), 32'd0);
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("late_ack_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        check_wb_zero("late_ack");
        bus.dmem_ack = 1'b0;
        m_rd = 5'd0; m_alu = 32'd0; m_m2r = 1'b0; m_mdata = 32'd0;

        // Randomized mix of bubbles, ALU ops, loads and stores with random latency.
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            lat  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 7);
            a    = $urandom;
            if (kind == 0) begin
                run_instr(1'b0, 1'($urandom_range(0, 1)), 1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b0,
                          5'($urandom), a, $urandom, $urandom, lat);
            end else if (kind <= 3) begin
                run_instr(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)),
                          5'($urandom), a, $urandom, $urandom, lat);
            end else if (kind <= 6) begin
                f3 = ld_f3[$urandom_range(0, 7)];
                run_instr(1'b1, 1'b1, 1'b0, f3, 1'b1, 1'($urandom_range(0, 1)),
                          5'($urandom), a, $urandom, $urandom, lat);
            end else begin
                f3 = 3'($urandom_range(0, 2));
                run_instr(1'b1, 1'b0, 1'b1, f3, 1'b0, 1'b0,
                          5'($urandom), a, $urandom, $urandom, lat);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
